// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD-host CMD-line engine.
//   Takes a command index, argument and response type from the host and
//   frames the 40-bit token {01, index, argument} for the PHY. It then waits
//   for the response frame, with a cycle timeout and automatic re-send, and
//   returns the unpacked response together with its status flags.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   new_command          host request, sampled only when idle
//   cmd_index/argument   command fields, captured on accept
//   resp_type            00 none, 01 short+index check, 10 long, 11 short
//   timeout_value        response wait limit in cycles (0 = forever)
//   serial_ready         PHY has finished shifting out the token
//   strobe_in / cmd_in   PHY response frame strobe and data
//   busy                 command in flight
//   strobe_out / cmd_out token to the PHY
//   ack_out              acknowledge of a received frame (same cycle)
//   response             unpacked response
//   command_complete     one-cycle completion pulse
//   command_timeout      sticky: final attempt timed out
//   command_index_error  sticky: short-checked index mismatch
//   retry_count          re-sends used by the current or last command
module sd_cmd_engine #(
    parameter int ARG_W     = 32,
    parameter int TIMEOUT_W = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 new_command,
    input  logic [5:0]           cmd_index,
    input  logic [ARG_W-1:0]     cmd_argument,
    input  logic [1:0]           resp_type,
    input  logic [TIMEOUT_W-1:0] timeout_value,
    input  logic                 serial_ready,
    input  logic                 strobe_in,
    input  logic [135:0]         cmd_in,
    output logic                 busy,
    output logic                 strobe_out,
    output logic [ARG_W+7:0]     cmd_out,
    output logic                 ack_out,
    output logic [127:0]         response,
    output logic                 command_complete,
    output logic                 command_timeout,
    output logic                 command_index_error,
    output logic [3:0]           retry_count
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;

    localparam logic [1:0] RESP_NONE  = 2'b00;
    localparam logic [1:0] RESP_SHORT = 2'b01;
    localparam logic [1:0] RESP_LONG  = 2'b10;

    state_t               state;
    logic [5:0]           idx_q;
    logic [1:0]           rtype_q;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic                 expire;

    // The counter holds the number of completed WAIT_RESP cycles, so the
    // cycle in which it would step to tmo_q is the last one allowed.
    assign cnt_inc = wait_cnt + TIMEOUT_W'(1);
    assign expire  = (tmo_q != '0) && (cnt_inc == tmo_q);

    // Acknowledge the frame in the very cycle it is presented.
    assign ack_out = (state == WAIT_RESP) && strobe_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            idx_q               <= '0;
            rtype_q             <= '0;
            tmo_q               <= '0;
            wait_cnt            <= '0;
            busy                <= 1'b0;
            strobe_out          <= 1'b0;
            cmd_out             <= '0;
            response            <= '0;
            command_complete    <= 1'b0;
            command_timeout     <= 1'b0;
            command_index_error <= 1'b0;
            retry_count         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (new_command) begin
                        idx_q               <= cmd_index;
                        rtype_q             <= resp_type;
                        tmo_q               <= timeout_value;
                        cmd_out             <= {2'b01, cmd_index, cmd_argument};
                        response            <= '0;
                        command_timeout     <= 1'b0;
                        command_index_error <= 1'b0;
                        retry_count         <= '0;
                        busy                <= 1'b1;
                        strobe_out          <= 1'b1;
                        state               <= SEND;
                    end
                end
                SEND: begin
                    if (serial_ready) begin
                        strobe_out <= 1'b0;
                        wait_cnt   <= '0;
                        if (rtype_q == RESP_NONE) begin
                            command_complete <= 1'b1;
                            state            <= DONE;
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    wait_cnt <= cnt_inc;
                    // A frame arriving on the expiry cycle takes priority.
                    if (strobe_in) begin
                        if (rtype_q == RESP_LONG)
                            response <= {8'h00, cmd_in[127:8]};
                        else
                            response <= {96'h0, cmd_in[39:8]};
                        if (rtype_q == RESP_SHORT && cmd_in[45:40] != idx_q)
                            command_index_error <= 1'b1;
                        command_complete <= 1'b1;
                        state            <= DONE;
                    end else if (expire) begin
                        if (retry_count < 4'(MAX_RETRY)) begin
                            retry_count <= retry_count + 4'd1;
                            wait_cnt    <= '0;
                            strobe_out  <= 1'b1;
                            state       <= SEND;
                        end else begin
                            command_timeout  <= 1'b1;
                            command_complete <= 1'b1;
                            state            <= DONE;
                        end
                    end
                end
                DONE: begin
                    command_complete <= 1'b0;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
module tb_sd_cmd_engine;
    localparam int ARG_W     = 32;
    localparam int TIMEOUT_W = 16;
    localparam int MAX_RETRY = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 new_command = 1'b0;
    logic [5:0]           cmd_index = '0;
    logic [ARG_W-1:0]     cmd_argument = '0;
    logic [1:0]           resp_type = '0;
    logic [TIMEOUT_W-1:0] timeout_value = '0;
    logic                 serial_ready = 1'b0;
    logic                 strobe_in = 1'b0;
    logic [135:0]         cmd_in = '0;
    logic                 busy, strobe_out, ack_out, command_complete;
    logic [ARG_W+7:0]     cmd_out;
    logic [127:0]         response;
    logic                 command_timeout, command_index_error;
    logic [3:0]           retry_count;

    sd_cmd_engine #(.ARG_W(ARG_W), .TIMEOUT_W(TIMEOUT_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clock(clock), .reset(reset), .new_command(new_command),
        .cmd_index(cmd_index), .cmd_argument(cmd_argument), .resp_type(resp_type),
        .timeout_value(timeout_value), .serial_ready(serial_ready),
        .strobe_in(strobe_in), .cmd_in(cmd_in), .busy(busy), .strobe_out(strobe_out),
        .cmd_out(cmd_out), .ack_out(ack_out), .response(response),
        .command_complete(command_complete), .command_timeout(command_timeout),
        .command_index_error(command_index_error), .retry_count(retry_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] resp;
        logic         tmo;
        logic         ierr;
        logic [3:0]   retry;
        int           sends;
        int           acks;
        int           waits;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: tallies token phases, acks and response-wait cycles, and on
    // each completion pops the expected outcome and compares.
    initial begin : monitor
        int sends, acks, waits;
        bit prev_so, chk_idle;
        exp_t e;
        sends = 0; acks = 0; waits = 0; prev_so = 0; chk_idle = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sends = 0; acks = 0; waits = 0; prev_so = 0; chk_idle = 0;
            end else begin
                if (chk_idle) begin
                    chk("busy_after_complete", 128'(busy), 128'(0));
                    chk_idle = 0;
                end
                if (strobe_out && !prev_so) sends++;
                prev_so = strobe_out;
                if (ack_out) acks++;
                if (busy && !strobe_out && !command_complete) waits++;
                if (command_complete) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_complete", 128'(1), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("response", response, e.resp);
                        chk("timeout_flag", 128'(command_timeout), 128'(e.tmo));
                        chk("index_error", 128'(command_index_error), 128'(e.ierr));
                        chk("retry_count", 128'(retry_count), 128'(e.retry));
                        chk("send_phases", 128'(sends), 128'(e.sends));
                        chk("ack_count", 128'(acks), 128'(e.acks));
                        chk("wait_cycles", 128'(waits), 128'(e.waits));
                    end
                    sends = 0; acks = 0; waits = 0; chk_idle = 1;
                end
            end
        end
    end

    task automatic wait_strobe(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (strobe_out) begin ok = 1; break; end
        end
        if (!ok) chk("strobe_out_wait", 128'(0), 128'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("busy_wait", 128'(1), 128'(0));
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [1:0] rt, input int tmo);
        @(posedge clock); #1;
        new_command = 1'b1; cmd_index = idx; cmd_argument = arg;
        resp_type = rt; timeout_value = TIMEOUT_W'(tmo);
        @(posedge clock); #1;
        new_command = 1'b0;
    endtask

    // nto: attempts that get no response; the response (if any) comes dly
    // cycles into the attempt after those.
    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int tmo, input int nto, input int dly, input logic [135:0] frame);
        exp_t e;
        bit ok;
        logic [39:0] tok;
        e.resp = '0; e.tmo = 0; e.ierr = 0; e.retry = '0; e.acks = 0; e.waits = 0;
        if (rt == 2'b00) begin
            e.sends = 1;
        end else if (nto > MAX_RETRY) begin
            e.tmo = 1; e.retry = 4'(MAX_RETRY); e.sends = MAX_RETRY + 1;
            e.waits = (MAX_RETRY + 1) * tmo;
        end else begin
            e.retry = 4'(nto); e.sends = nto + 1; e.acks = 1;
            e.waits = nto * tmo + dly + 1;
            if (rt == 2'b10) e.resp = {8'h00, frame[127:8]};
            else             e.resp = {96'h0, frame[39:8]};
            e.ierr = (rt == 2'b01) && (frame[45:40] != idx);
        end
        sb.push_back(e);
        tok = {2'b01, idx, arg};
        start_cmd(idx, arg, rt, tmo);
        for (int att = 0; att <= MAX_RETRY; att++) begin
            wait_strobe(ok);
            if (!ok) break;
            chk("cmd_out", 128'(cmd_out), 128'(tok));
            if (att == 0) chk("response_cleared", response, 128'(0));
            @(posedge clock); #1;
            serial_ready = 1'b1;
            // A request while busy must not be re-captured.
            if (att == 0) begin new_command = 1'b1; cmd_index = ~idx; end
            @(posedge clock); #1;
            serial_ready = 1'b0; new_command = 1'b0;
            if (rt == 2'b00) break;
            if (att == nto) begin
                repeat (dly) begin @(posedge clock); #1; end
                strobe_in = 1'b1; cmd_in = frame;
                @(negedge clock);
                chk("ack_out", 128'(ack_out), 128'(1));
                @(posedge clock); #1;
                strobe_in = 1'b0;
                break;
            end
        end
        wait_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_strobe_out"}, 128'(strobe_out), 128'(0));
        chk({tag, "_cmd_out"}, 128'(cmd_out), 128'(0));
        chk({tag, "_ack_out"}, 128'(ack_out), 128'(0));
        chk({tag, "_response"}, response, 128'(0));
        chk({tag, "_complete"}, 128'(command_complete), 128'(0));
        chk({tag, "_timeout"}, 128'(command_timeout), 128'(0));
        chk({tag, "_index_error"}, 128'(command_index_error), 128'(0));
        chk({tag, "_retry_count"}, 128'(retry_count), 128'(0));
    endtask

    initial begin : driver
        logic [135:0] f;
        logic [159:0] r;
        logic [5:0]   idx;
        int rt, tmo, nto, dly;
        bit ok;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_all_zero("reset");

        // CMD0, no response: token 0x4000000000
        f = '0;
        issue(6'd0, 32'h0, 2'b00, 0, 0, 0, f);
        chk("cmd0_token", 128'(cmd_out), 128'(40'h40_0000_0000));

        // CMD17 short checked, matching index
        f = '0; f[45:40] = 6'd17; f[39:8] = 32'h0000_0900;
        issue(6'd17, 32'h0000_1000, 2'b01, 50, 0, 3, f);
        // same with wrong index
        f[45:40] = 6'd5;
        issue(6'd17, 32'h0000_1000, 2'b01, 50, 0, 2, f);

        // CMD2 long response
        f = {17{8'hA5}};
        issue(6'd2, 32'h0, 2'b10, 0, 0, 7, f);

        // No response at all: three sends, timeout after 10-cycle waits
        issue(6'd8, 32'h1AA, 2'b01, 10, MAX_RETRY + 1, 0, f);
        // Response on the expiry cycle of the second attempt
        f = {17{8'h3C}}; f[45:40] = 6'd9;
        issue(6'd9, 32'hDEAD_BEEF, 2'b01, 10, 1, 9, f);
        // Short without index check, wait forever
        issue(6'd13, 32'h5, 2'b11, 0, 0, 30, f);

        // strobe_in while idle: no ack, no completion
        @(posedge clock); #1 strobe_in = 1'b1;
        @(negedge clock);
        chk("idle_ack_out", 128'(ack_out), 128'(0));
        @(posedge clock); #1 strobe_in = 1'b0;

        // Reset while waiting for the response: abort, no completion
        start_cmd(6'd17, 32'h77, 2'b01, 0);
        wait_strobe(ok);
        @(posedge clock); #1 serial_ready = 1'b1;
        @(posedge clock); #1 serial_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk_all_zero("abort");
        repeat (5) @(posedge clock);

        for (int n = 0; n < 40; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            f = r[135:0];
            idx = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) f[45:40] = idx;
            rt = $urandom_range(0, 3);
            tmo = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15);
            nto = (rt == 0 || tmo == 0) ? 0 : $urandom_range(0, MAX_RETRY + 1);
            dly = (tmo == 0) ? $urandom_range(0, 20) : $urandom_range(0, tmo - 1);
            issue(idx, $urandom, 2'(rt), tmo, nto, dly, f);
        end

        repeat (5) @(posedge clock);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
